decision_order_unit: RTL and testbench

//  Parametrised successor to the old decider: holds the static decision order (variable index +

---
 rtl/decision_order_unit_pkg.sv | 22 ++
 rtl/decision_order_unit_trail.sv | 33 +++
 rtl/decision_order_unit.sv | 197 +++++++++++++++++++
 tb/tb_decision_order_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decision_order_unit_pkg.sv
// Shared types for the decision order unit: the order-table entry format
// and the controller state encoding.
package decision_order_unit_pkg;

    // Widest variable index an order-table entry can carry.
    localparam int MAX_VARS_BITS = 6;
    localparam int DOU_MAX_VARS  = 1 << MAX_VARS_BITS;

    // One order-table slot: which variable to decide next and its preferred polarity.
    typedef struct packed {
        logic [MAX_VARS_BITS-1:0] var_idx;
        logic                     val;
    } config_var;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } dou_state_e;

endpackage

// File: rtl/decision_order_unit_trail.sv
// Trail stack for the decision order unit. Slot k holds the scan position of
// the decision that created level k+1, so a backtrack to level k resumes the
// scan exactly at the first undone decision.
module decision_trail_stack #(
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = $clog2(DEPTH),
    parameter int DATA_BITS = 7
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Record the scan position of an accepted decision at the current level.
    // NOTE: the storage is deliberately not reset; a level is always pushed before
    // a backtrack can target it, so stale contents are never observed.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignment for all clocked state so every flop
        // samples pre-edge values regardless of statement order.
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read so a backtrack restores the position in the same cycle.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/decision_order_unit.sv
// Decision order unit: walks a static order table, skips variables already
// assigned, and presents the next free variable to Control over valid/ready.
// A per-level trail lets Control backtrack by decision level.
module decision_order_unit
    import decision_order_unit_pkg::*;
#(
    parameter int MAX_VARS   = DOU_MAX_VARS,
    parameter int VAR_BITS   = $clog2(MAX_VARS),
    parameter int MAX_LEVELS = MAX_VARS,
    parameter int LVL_BITS   = $clog2(MAX_LEVELS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [VAR_BITS-1:0] cfg_addr,
    input  config_var           cfg_entry,
    input  logic [VAR_BITS:0]   num_vars,
    input  logic                start,
    input  logic [MAX_VARS-1:0] assigned_mask,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [VAR_BITS-1:0] dec_var,
    output logic                dec_val,
    output logic [LVL_BITS-1:0] dec_level,
    input  logic                bt_valid,
    input  logic [LVL_BITS-1:0] bt_level,
    output logic                done,
    output logic                err_overflow
);

    localparam int                TRAIL_AW  = $clog2(MAX_LEVELS);
    localparam logic [LVL_BITS-1:0] LVL_FULL = LVL_BITS'(MAX_LEVELS);

    // Order table: written only while idle, read asynchronously at the scan position.
    logic [VAR_BITS-1:0] tbl_var [MAX_VARS];
    logic                tbl_val [MAX_VARS];

    dou_state_e          state_q,     state_d;
    logic [VAR_BITS:0]   pos_q,       pos_d;
    logic [VAR_BITS:0]   len_q,       len_d;
    logic [LVL_BITS-1:0] level_q,     level_d;
    logic                dec_valid_q, dec_valid_d;
    logic [VAR_BITS-1:0] dec_var_q,   dec_var_d;
    logic                dec_val_q,   dec_val_d;
    logic [LVL_BITS-1:0] dec_level_q, dec_level_d;
    logic                done_q,      done_d;
    logic                err_q,       err_d;

    logic                trail_we;
    logic [VAR_BITS:0]   trail_rdata;
    logic [VAR_BITS-1:0] cur_var;
    logic                cur_val;
    logic                bt_take;
    logic                accept;

    // Table write port; configuration is frozen once scanning has begun.
    always_ff @(posedge clock) begin
        if (cfg_we && state_q == IDLE) begin
            tbl_var[cfg_addr] <= cfg_entry.var_idx[VAR_BITS-1:0];
            tbl_val[cfg_addr] <= cfg_entry.val;
        end
    end

    assign cur_var = tbl_var[pos_q[VAR_BITS-1:0]];
    assign cur_val = tbl_val[pos_q[VAR_BITS-1:0]];

    // A backtrack only counts when it actually undoes at least one level.
    assign bt_take = bt_valid && (state_q != IDLE) && (bt_level < level_q);
    assign accept  = (state_q == PRESENT) && dec_valid_q && dec_ready;

    decision_trail_stack #(
        .DEPTH     (MAX_LEVELS),
        .ADDR_BITS (TRAIL_AW),
        .DATA_BITS (VAR_BITS + 1)
    ) u_trail (
        .clock   (clock),
        .we      (trail_we),
        .wr_addr (level_q[TRAIL_AW-1:0]),
        .wr_data (pos_q),
        .rd_addr (bt_level[TRAIL_AW-1:0]),
        .rd_data (trail_rdata)
    );

    // Next-state logic for the scan controller and its registered outputs.
    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        pos_d       = pos_q;
        len_d       = len_q;
        level_d     = level_q;
        dec_valid_d = dec_valid_q;
        dec_var_d   = dec_var_q;
        dec_val_d   = dec_val_q;
        dec_level_d = dec_level_q;
        done_d      = done_q;
        err_d       = err_q;
        trail_we    = 1'b0;

        if (bt_take) begin
            // Backtrack outranks a same-cycle accept: the accept is simply dropped.
            pos_d       = trail_rdata;
            level_d     = bt_level;
            dec_valid_d = 1'b0;
            done_d      = 1'b0;
            state_d     = SCAN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_d   = num_vars;
                        pos_d   = '0;
                        level_d = '0;
                        if (num_vars == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (pos_q == len_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (assigned_mask[cur_var]) begin
                        pos_d = pos_q + 1'b1;
                    end else begin
                        dec_var_d   = cur_var;
                        dec_val_d   = cur_val;
                        dec_level_d = level_q + 1'b1;
                        dec_valid_d = 1'b1;
                        state_d     = PRESENT;
                    end
                end
                PRESENT: begin
                    // The presented decision is held even if the mask changes meanwhile.
                    if (accept) begin
                        dec_valid_d = 1'b0;
                        state_d     = SCAN;
                        if (level_q == LVL_FULL) begin
                            // Trail full: record the error and drop the decision;
                            // the scan resumes at the same entry.
                            err_d = 1'b1;
                        end else begin
                            trail_we = 1'b1;
                            level_d  = level_q + 1'b1;
                            pos_d    = pos_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    dec_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Controller state registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            len_q       <= '0;
            level_q     <= '0;
            dec_valid_q <= 1'b0;
            dec_var_q   <= '0;
            dec_val_q   <= 1'b0;
            dec_level_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            len_q       <= len_d;
            level_q     <= level_d;
            dec_valid_q <= dec_valid_d;
            dec_var_q   <= dec_var_d;
            dec_val_q   <= dec_val_d;
            dec_level_q <= dec_level_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign dec_valid    = dec_valid_q;
    assign dec_var      = dec_var_q;
    assign dec_val      = dec_val_q;
    assign dec_level    = dec_level_q;
    assign done         = done_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_decision_order_unit.sv
// Bench for decision_order_unit: table-driven scan sequences checked through a
// scoreboard queue, plus hand-written handshake, backtrack and overflow cases.
module tb_decision_order_unit;
    import decision_order_unit_pkg::*;

    localparam int VB = 6;
    localparam int LB = 7;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            cfg_we = 1'b0;
    logic [VB-1:0]   cfg_addr = '0;
    config_var       cfg_entry = '0;
    logic [VB:0]     num_vars = '0;
    logic            start = 1'b0;
    logic [63:0]     assigned_mask = '0;
    logic            dec_ready = 1'b0;
    logic            bt_valid = 1'b0;
    logic [LB-1:0]   bt_level = '0;

    logic            dec_valid, dec_val, done, err_overflow;
    logic [VB-1:0]   dec_var;
    logic [LB-1:0]   dec_level;

    logic            s_dec_valid, s_dec_val, s_done, s_err;
    logic [VB-1:0]   s_dec_var;
    logic [1:0]      s_dec_level;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    decision_order_unit u_dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_entry(cfg_entry), .num_vars(num_vars), .start(start),
        .assigned_mask(assigned_mask), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_var(dec_var), .dec_val(dec_val), .dec_level(dec_level),
        .bt_valid(bt_valid), .bt_level(bt_level), .done(done), .err_overflow(err_overflow)
    );

    decision_order_unit #(.MAX_LEVELS(2)) u_small (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_entry(cfg_entry), .num_vars(num_vars), .start(start),
        .assigned_mask(assigned_mask), .dec_valid(s_dec_valid), .dec_ready(dec_ready),
        .dec_var(s_dec_var), .dec_val(s_dec_val), .dec_level(s_dec_level),
        .bt_valid(bt_valid), .bt_level(bt_level[1:0]), .done(s_done), .err_overflow(s_err)
    );

    typedef struct {
        int var_i;
        int val;
        int lvl;
        int cyc;
    } exp_dec_t;

    typedef struct packed {
        logic [6:0]      nv;
        logic [63:0]     mask;
        logic [1:0]      n;
        logic [2:0][5:0] vars;
        logic [2:0]      vals;
        logic [2:0][7:0] cycs;
        logic [7:0]      done_cyc;
    } vec_t;

    exp_dec_t sb[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        cfg_we    = 1'b0;
        start     = 1'b0;
        dec_ready = 1'b0;
        bt_valid  = 1'b0;
        bt_level  = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Order table: slot0 = 3:1, slot1 = 0:0, slot2 = 2:1, slot3 = 1:0.
    task automatic load_order();
        logic [5:0] v [4];
        logic       p [4];
        v[0] = 6'd3; p[0] = 1'b1;
        v[1] = 6'd0; p[1] = 1'b0;
        v[2] = 6'd2; p[2] = 1'b1;
        v[3] = 6'd1; p[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_we    = 1'b1;
            cfg_addr  = VB'(i);
            cfg_entry = '{var_idx: v[i], val: p[i]};
            step();
        end
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [6:0] nv);
        num_vars = nv;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!dec_valid && n < 20) begin
            step();
            n++;
        end
        check({nm, "_valid"}, dec_valid, 1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check({nm, "_done"}, done, 1);
    endtask

    task automatic check_dec(input string nm, input int v, input int p, input int l);
        check(nm, {dec_valid, dec_var, dec_val, dec_level},
              {1'b1, 6'(v), 1'(p), 7'(l)});
    endtask

    function automatic vec_t mk(input int nv, input logic [63:0] mask, input int n,
                                input int v0, input int v1, input int v2,
                                input int p0, input int p1, input int p2,
                                input int c0, input int c1, input int c2, input int dc);
        vec_t r;
        r.nv       = 7'(nv);
        r.mask     = mask;
        r.n        = 2'(n);
        r.vars     = {6'(v2), 6'(v1), 6'(v0)};
        r.vals     = {1'(p2), 1'(p1), 1'(p0)};
        r.cycs     = {8'(c2), 8'(c1), 8'(c0)};
        r.done_cyc = 8'(dc);
        return r;
    endfunction

    initial begin
        vec_t     vecs [6];
        exp_dec_t e;
        int       c;
        bit       fin;

        // {num_vars, mask, count, vars, vals, cycle of each dec_valid, cycle of done}
        vecs[0] = mk(3, 64'h0, 3, 3, 0, 2, 1, 0, 1, 1, 3, 5, 7);
        vecs[1] = mk(3, 64'h1, 2, 3, 2, 0, 1, 1, 0, 1, 4, 0, 6);
        vecs[2] = mk(3, 64'hC, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 5);
        vecs[3] = mk(3, 64'hD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        vecs[4] = mk(0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5] = mk(2, 64'h0, 2, 3, 0, 0, 1, 0, 0, 1, 3, 0, 5);

        // Table-driven scan sequences with ready held high.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            load_order();
            assigned_mask = vecs[t].mask;
            dec_ready     = 1'b1;
            for (int i = 0; i < int'(vecs[t].n); i++) begin
                e.var_i = int'(vecs[t].vars[i]);
                e.val   = int'(vecs[t].vals[i]);
                e.lvl   = i + 1;
                e.cyc   = int'(vecs[t].cycs[i]);
                sb.push_back(e);
            end
            do_start(vecs[t].nv);
            c   = 0;
            fin = 1'b0;
            while (!fin) begin
                if (dec_valid) begin
                    check($sformatf("v%0d_sb_pending", t), sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check($sformatf("v%0d_dec", t), {dec_var, dec_val, dec_level},
                              {6'(e.var_i), 1'(e.val), 7'(e.lvl)});
                        check($sformatf("v%0d_dec_cycle", t), c, e.cyc);
                    end
                end
                if (done) begin
                    check($sformatf("v%0d_done_cycle", t), c, vecs[t].done_cyc);
                    check($sformatf("v%0d_sb_empty", t), sb.size(), 0);
                    check($sformatf("v%0d_done_no_valid", t), dec_valid, 0);
                    fin = 1'b1;
                end else if (c > 40) begin
                    check($sformatf("v%0d_done_in_time", t), done, 1);
                    sb.delete();
                    fin = 1'b1;
                end else begin
                    step();
                    c++;
                end
            end
        end

        // Reset state, then ready held low: outputs stay put, mask change does not revoke.
        do_reset();
        check("reset_outputs", {dec_valid, dec_var, dec_val, dec_level, done, err_overflow}, 0);
        load_order();
        assigned_mask = '0;
        do_start(7'd3);
        wait_valid("hold");
        check_dec("hold_first", 3, 1, 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) assigned_mask[3] = 1'b1;
            step();
            check_dec($sformatf("hold_stable%0d", k), 3, 1, 1);
        end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("accept_drops_valid", dec_valid, 0);
        wait_valid("after_accept");
        check_dec("single_push", 0, 0, 2);

        // Finish the run, then backtrack to level 1 from DONE.
        dec_ready = 1'b1;
        wait_done("run_to_done");
        check("done_no_valid", dec_valid, 0);
        dec_ready = 1'b0;
        bt_valid  = 1'b1;
        bt_level  = 7'd1;
        step();
        bt_valid  = 1'b0;
        check("bt_clears", {dec_valid, done}, 0);
        wait_valid("bt1");
        check_dec("bt1_redecide", 0, 0, 2);

        // Reach level 2, then a backtrack to a level not below it is ignored.
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        wait_valid("lvl2");
        check_dec("lvl2_present", 2, 1, 3);
        bt_valid = 1'b1;
        bt_level = 7'd3;
        step();
        check_dec("bt_above_ignored", 2, 1, 3);
        bt_level = 7'd2;
        step();
        bt_valid = 1'b0;
        check_dec("bt_equal_ignored", 2, 1, 3);

        // Back to level 1, then accept and backtrack in the same cycle.
        assigned_mask = '0;
        bt_valid = 1'b1;
        bt_level = 7'd1;
        step();
        bt_valid = 1'b0;
        wait_valid("lvl1");
        check_dec("lvl1_present", 0, 0, 2);
        dec_ready = 1'b1;
        bt_valid  = 1'b1;
        bt_level  = 7'd0;
        step();
        dec_ready = 1'b0;
        bt_valid  = 1'b0;
        check("collide_valid_low", dec_valid, 0);
        wait_valid("collide");
        check_dec("collide_bt_wins", 3, 1, 1);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        wait_valid("post_collide");
        check_dec("post_collide_level", 0, 0, 2);

        // Trail overflow on the two-level instance, then reset mid-run.
        do_reset();
        load_order();
        assigned_mask = '0;
        dec_ready     = 1'b1;
        do_start(7'd3);
        for (int k = 0; k < 5; k++) step();
        check("ovf_third_present", {s_dec_valid, s_dec_var, s_dec_level}, {1'b1, 6'd2, 2'd3});
        check("ovf_not_yet", s_err, 0);
        step();
        check("ovf_set", s_err, 1);
        step();
        check("ovf_sticky", {s_err, s_dec_valid, s_dec_var}, {1'b1, 1'b1, 6'd2});
        reset = 1'b0;
        step();
        check("midrun_reset_small",
              {s_dec_valid, s_dec_var, s_dec_val, s_dec_level, s_done, s_err}, 0);
        check("midrun_reset_main",
              {dec_valid, dec_var, dec_val, dec_level, done, err_overflow}, 0);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
